// File: rtl/eql_cmp_search.sv
// eql_cmp_search -- sequential first-match search over a small reference table.
//
// A single eql_cmp comparator is time-shared across DEPTH table entries. The
// scan visits one entry per cycle, starting at index 0, so the lowest matching
// index always wins.
//
// Ports
//   clk, rst_n        clock (rising edge), asynchronous active-low reset
//   wr_ena/adr/dat    table write; a write also marks that entry valid
//   clr_ena           clear all valid bits (a same-cycle write still lands)
//   req_vld/rdy/val   search request handshake and search value
//   rsp_vld/rdy       response handshake
//   rsp_hit, rsp_idx  match flag and lowest matching index (0 on miss)

module eql_cmp #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             eql
);
  assign eql = (a == b);
endmodule

module eql_cmp_search #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_ena,
  input  logic [$clog2(DEPTH)-1:0] wr_adr,
  input  logic [WIDTH-1:0]         wr_dat,
  input  logic                     clr_ena,
  input  logic                     req_vld,
  output logic                     req_rdy,
  input  logic [WIDTH-1:0]         req_val,
  output logic                     rsp_vld,
  input  logic                     rsp_rdy,
  output logic                     rsp_hit,
  output logic [$clog2(DEPTH)-1:0] rsp_idx
);
  localparam int DEPTH_LOG = $clog2(DEPTH);
  localparam logic [DEPTH_LOG-1:0] LAST_IDX = DEPTH_LOG'(DEPTH - 1);

  typedef enum logic [1:0] {IDLE, SCAN, RESP} state_t;

  state_t               state;
  logic [WIDTH-1:0]     tbl [DEPTH];
  logic [DEPTH-1:0]     vld;
  logic [DEPTH-1:0]     vld_nxt;
  logic [WIDTH-1:0]     key;
  logic [DEPTH_LOG-1:0] idx;
  logic                 eql;
  logic                 wr_ok;

  // Out-of-range addresses (non-power-of-two DEPTH) are ignored.
  assign wr_ok = wr_ena && (int'(wr_adr) < DEPTH);

  // The compare reads the registered table and valid bits, so a write landing
  // on the entry under compare only shows up on a later pass.
  eql_cmp #(.WIDTH(WIDTH)) u_cmp (
    .a   (tbl[idx]),
    .b   (key),
    .eql (eql)
  );

  // Clear first, then the write, so clr+wr leaves exactly the written entry valid.
  always_comb begin
    vld_nxt = clr_ena ? '0 : vld;
    if (wr_ok) vld_nxt[wr_adr] = 1'b1;
  end

  // Table contents and search key are pure data: no reset.
  always_ff @(posedge clk) begin
    if (wr_ok) tbl[wr_adr] <= wr_dat;
  end

  always_ff @(posedge clk) begin
    if (req_vld && req_rdy) key <= req_val;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      vld     <= '0;
      idx     <= '0;
      req_rdy <= 1'b1;
      rsp_vld <= 1'b0;
      rsp_hit <= 1'b0;
      rsp_idx <= '0;
    end else begin
      vld <= vld_nxt;
      case (state)
        IDLE: begin
          if (req_vld && req_rdy) begin
            idx     <= '0;
            req_rdy <= 1'b0;
            state   <= SCAN;
          end
        end
        SCAN: begin
          if (eql && vld[idx]) begin
            rsp_hit <= 1'b1;
            rsp_idx <= idx;
            rsp_vld <= 1'b1;
            state   <= RESP;
          end else if (idx == LAST_IDX) begin
            // Stop at the last real entry; never wrap into unused codes.
            rsp_hit <= 1'b0;
            rsp_idx <= '0;
            rsp_vld <= 1'b1;
            state   <= RESP;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        RESP: begin
          if (rsp_rdy) begin
            rsp_vld <= 1'b0;
            req_rdy <= 1'b1;
            state   <= IDLE;
          end
        end
        default: begin
          rsp_vld <= 1'b0;
          req_rdy <= 1'b1;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_eql_cmp_search.sv
module tb_eql_cmp_search;
  localparam int WIDTH = 4;
  localparam int DEPTH = 8;
  localparam int DL    = 3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          wr_ena;
  logic [DL-1:0] wr_adr;
  logic [3:0]    wr_dat;
  logic          clr_ena;
  logic          req_vld;
  logic          req_rdy;
  logic [3:0]    req_val;
  logic          rsp_vld;
  logic          rsp_rdy;
  logic          rsp_hit;
  logic [DL-1:0] rsp_idx;

  eql_cmp_search #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .wr_ena(wr_ena), .wr_adr(wr_adr), .wr_dat(wr_dat),
    .clr_ena(clr_ena), .req_vld(req_vld), .req_rdy(req_rdy), .req_val(req_val),
    .rsp_vld(rsp_vld), .rsp_rdy(rsp_rdy), .rsp_hit(rsp_hit), .rsp_idx(rsp_idx)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks   = 0;
  int failures = 0;
  int acc_cyc  = 0;

  // Reference model: table contents and valid flags as plain arrays.
  int m_tbl [DEPTH];
  bit m_vld [DEPTH];

  typedef struct {
    logic [3:0] val;
    int         hit;
    int         idx;
    int         lat;
    int         hold;
  } vec_t;
  vec_t vecs [8];

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic bound_fail(input string nm);
    checks++;
    failures++;
    $display("FAIL %s: timed out", nm);
  endtask

  // All drive tasks start and end 1 time unit after a rising edge.
  task automatic do_write(input int adr, input int dat);
    wr_ena = 1'b1; wr_adr = DL'(adr); wr_dat = 4'(dat);
    @(posedge clk); #1;
    wr_ena = 1'b0;
    m_tbl[adr] = dat; m_vld[adr] = 1'b1;
  endtask

  task automatic do_clear();
    clr_ena = 1'b1;
    @(posedge clk); #1;
    clr_ena = 1'b0;
    for (int i = 0; i < DEPTH; i++) m_vld[i] = 1'b0;
  endtask

  task automatic do_clr_wr(input int adr, input int dat);
    clr_ena = 1'b1; wr_ena = 1'b1; wr_adr = DL'(adr); wr_dat = 4'(dat);
    @(posedge clk); #1;
    clr_ena = 1'b0; wr_ena = 1'b0;
    for (int i = 0; i < DEPTH; i++) m_vld[i] = 1'b0;
    m_tbl[adr] = dat; m_vld[adr] = 1'b1;
  endtask

  task automatic ref_search(input int val, output int hit, output int idx, output int lat);
    hit = 0; idx = 0; lat = DEPTH;
    for (int i = DEPTH - 1; i >= 0; i--)
      if (m_vld[i] && m_tbl[i] == val) begin
        hit = 1; idx = i; lat = i + 1;
      end
  endtask

  task automatic start_req(input int val, output bit ok);
    int n = 0;
    while (!req_rdy && n < 32) begin @(posedge clk); #1; n++; end
    if (!req_rdy) begin bound_fail("req_rdy_wait"); ok = 0; return; end
    req_vld = 1'b1; req_val = 4'(val);
    @(posedge clk); #1;
    req_vld = 1'b0;
    acc_cyc = cyc;
    ok = 1;
  endtask

  task automatic wait_rsp(input int hold, output int hit, output int idx,
                          output int lat, output bit ok);
    int n = 0;
    hit = 0; idx = 0; lat = 0;
    while (!rsp_vld && n < 64) begin @(posedge clk); #1; n++; end
    if (!rsp_vld) begin bound_fail("rsp_vld_wait"); ok = 0; return; end
    lat = cyc - acc_cyc;
    hit = int'(rsp_hit);
    idx = int'(rsp_idx);
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      chk("hold_stable", {28'd0, rsp_vld, rsp_hit, rsp_idx, req_rdy} & 32'h3F,
          (1 << 5) | (hit << 4) | (idx << 1));
    end
    rsp_rdy = 1'b1;
    @(posedge clk); #1;
    rsp_rdy = 1'b0;
    chk("post_handshake_vld_rdy", {30'd0, rsp_vld, req_rdy}, 1);
    ok = 1;
  endtask

  task automatic search_chk(input string nm, input int val, input int ehit,
                            input int eidx, input int elat, input int hold);
    bit ok; int hit, idx, lat;
    start_req(val, ok);
    if (!ok) return;
    wait_rsp(hold, hit, idx, lat, ok);
    if (!ok) return;
    chk({nm, "_hit"}, hit, ehit);
    chk({nm, "_idx"}, idx, eidx);
    chk({nm, "_lat"}, lat, elat);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok, abort;
    int hit, idx, lat, eh, ei, el, bad;

    rst_n = 1'b0; wr_ena = 1'b0; wr_adr = '0; wr_dat = '0; clr_ena = 1'b0;
    req_vld = 1'b0; req_val = '0; rsp_rdy = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin m_tbl[i] = 0; m_vld[i] = 1'b0; end
    repeat (2) @(posedge clk); #1;
    chk("reset_req_rdy", int'(req_rdy), 1);
    chk("reset_rsp_vld", int'(rsp_vld), 0);
    chk("reset_rsp_hit", int'(rsp_hit), 0);
    chk("reset_rsp_idx", int'(rsp_idx), 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Empty table: full-length miss.
    search_chk("empty_miss", 5, 0, 0, 8, 0);

    // Fixed table; entry 5 deliberately left invalid.
    do_write(0, 4'h1); do_write(1, 4'h2); do_write(2, 4'h7); do_write(3, 4'h5);
    do_write(4, 4'hC); do_write(6, 4'h5); do_write(7, 4'hF);
    vecs[0] = '{val: 4'h5, hit: 1, idx: 3, lat: 4, hold: 5};
    vecs[1] = '{val: 4'h1, hit: 1, idx: 0, lat: 1, hold: 0};
    vecs[2] = '{val: 4'h2, hit: 1, idx: 1, lat: 2, hold: 1};
    vecs[3] = '{val: 4'hF, hit: 1, idx: 7, lat: 8, hold: 0};
    vecs[4] = '{val: 4'hC, hit: 1, idx: 4, lat: 5, hold: 2};
    vecs[5] = '{val: 4'h7, hit: 1, idx: 2, lat: 3, hold: 0};
    vecs[6] = '{val: 4'h0, hit: 0, idx: 0, lat: 8, hold: 0};
    vecs[7] = '{val: 4'hA, hit: 0, idx: 0, lat: 8, hold: 3};
    for (int v = 0; v < 8; v++)
      search_chk($sformatf("vec%0d", v), vecs[v].val, vecs[v].hit,
                 vecs[v].idx, vecs[v].lat, vecs[v].hold);

    // Write to a not-yet-scanned entry while idx==1 is being compared.
    do_clear();
    start_req(4'hA, ok);
    @(posedge clk); #1;
    wr_ena = 1'b1; wr_adr = 3'd5; wr_dat = 4'hA;
    @(posedge clk); #1;
    wr_ena = 1'b0;
    wait_rsp(0, hit, idx, lat, ok);
    chk("ahead_write_hit", hit, 1);
    chk("ahead_write_idx", idx, 5);
    chk("ahead_write_lat", lat, 6);

    // Write to the entry under compare: old contents are used.
    do_clear();
    start_req(4'hA, ok);
    repeat (2) begin @(posedge clk); #1; end
    wr_ena = 1'b1; wr_adr = 3'd2; wr_dat = 4'hA;
    @(posedge clk); #1;
    wr_ena = 1'b0;
    wait_rsp(0, hit, idx, lat, ok);
    chk("same_write_hit", hit, 0);
    chk("same_write_lat", lat, 8);
    search_chk("same_write_landed", 4'hA, 1, 2, 3, 0);

    // Clear during scan with a match ahead.
    do_clear();
    do_write(6, 4'hA);
    start_req(4'hA, ok);
    repeat (2) begin @(posedge clk); #1; end
    clr_ena = 1'b1;
    @(posedge clk); #1;
    clr_ena = 1'b0;
    wait_rsp(0, hit, idx, lat, ok);
    chk("scan_clear_hit", hit, 0);
    chk("scan_clear_idx", idx, 0);

    // Clear and write together: clear first, written entry survives.
    do_clear();
    do_write(1, 4'hB);
    do_clr_wr(3, 4'hB);
    search_chk("clr_wr_same", 4'hB, 1, 3, 4, 0);

    // Reset mid-scan aborts the search.
    do_write(7, 4'hD);
    start_req(4'hD, ok);
    repeat (3) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    #1;
    chk("midreset_rsp_vld", int'(rsp_vld), 0);
    chk("midreset_req_rdy", int'(req_rdy), 1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    bad = 0;
    repeat (12) begin @(posedge clk); #1; if (rsp_vld || !req_rdy) bad++; end
    chk("midreset_no_rsp", bad, 0);
    for (int i = 0; i < DEPTH; i++) m_vld[i] = 1'b0;
    search_chk("midreset_vld_cleared", 4'hD, 0, 0, 8, 0);

    // Randomized searches against the first-match model.
    abort = 0;
    do_clear();
    for (int s = 0; s < 1000 && !abort; s++) begin
      int nw = $urandom_range(0, 3);
      for (int w = 0; w < nw; w++) begin
        int r = $urandom_range(0, 15);
        int a = $urandom_range(0, DEPTH - 1);
        int d = $urandom_range(0, 15);
        if (r == 0) do_clear();
        else if (r == 1) do_clr_wr(a, d);
        else do_write(a, d);
      end
      begin
        int val = $urandom_range(0, 15);
        int hold = $urandom_range(0, 3);
        ref_search(val, eh, ei, el);
        start_req(val, ok);
        if (!ok) begin abort = 1; continue; end
        wait_rsp(hold, hit, idx, lat, ok);
        if (!ok) begin abort = 1; continue; end
        chk("rand_hit", hit, eh);
        chk("rand_idx", idx, ei);
        chk("rand_lat", lat, el);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
